// File: rtl/nibble_pack_8b.sv
// Packs pairs of 4-bit nibbles (low first) into bytes behind a one-byte output register.
// Define PACK_FLUSH_EN to add the flush port that pads out a held low nibble.
module nibble_pack_8b (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] in_,
    input  logic       in_val,
    output logic       in_rdy,
    output logic [7:0] out_,
    output logic       out_val,
    input  logic       out_rdy,
`ifdef PACK_FLUSH_EN
    input  logic       flush,
`endif
    output logic       half
);

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_e;

    state_e     state_q;
    logic [3:0] lo_q;
    logic [7:0] out_q;
    logic       out_val_q;

    logic in_fire;
    logic out_fire;
    logic slot_free;
    logic flush_go;

    // A low nibble never needs the output slot, so EMPTY always accepts.
    assign slot_free = !out_val_q || out_rdy;
    assign in_rdy    = (state_q == EMPTY) || slot_free;
    assign in_fire   = in_val && in_rdy;
    assign out_fire  = out_val_q && out_rdy;

`ifdef PACK_FLUSH_EN
    assign flush_go = flush && (state_q == HALF) && !in_fire && slot_free;
`else
    assign flush_go = 1'b0;
`endif

    assign out_    = out_q;
    assign out_val = out_val_q;
    assign half    = (state_q == HALF);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            lo_q      <= 4'h0;
            out_q     <= 8'h00;
            out_val_q <= 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (out_fire) begin
                        out_val_q <= 1'b0;
                    end
                    if (in_fire) begin
                        lo_q    <= in_;
                        state_q <= HALF;
                    end
                end
                HALF: begin
                    if (in_fire) begin
                        out_q     <= {in_, lo_q};
                        out_val_q <= 1'b1;
                        state_q   <= EMPTY;
                    end else if (flush_go) begin
                        out_q     <= {4'h0, lo_q};
                        out_val_q <= 1'b1;
                        state_q   <= EMPTY;
                    end else if (out_fire) begin
                        out_val_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_pack_8b.sv
// Directed bench for nibble_pack_8b: reset, packing, streaming, back-pressure, flush.
// Flush checks are compiled only when PACK_FLUSH_EN is defined.
module tb_nibble_pack_8b;

    logic       clk;
    logic       reset_n;
    logic [3:0] in_;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] out_;
    logic       out_val;
    logic       out_rdy;
    logic       half;
`ifdef PACK_FLUSH_EN
    logic       flush;
`endif

    int tests;
    int fails;

    nibble_pack_8b dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_     (in_),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .out_    (out_),
        .out_val (out_val),
        .out_rdy (out_rdy),
`ifdef PACK_FLUSH_EN
        .flush   (flush),
`endif
        .half    (half)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset_n = 1'b0;
        in_     = 4'h0;
        in_val  = 1'b0;
        out_rdy = 1'b1;
`ifdef PACK_FLUSH_EN
        flush   = 1'b0;
`endif
        tick();
        tick();
        chk("rst_out_val", {7'd0, out_val}, 8'd0);
        chk("rst_half", {7'd0, half}, 8'd0);
        chk("rst_in_rdy", {7'd0, in_rdy}, 8'd1);
        chk("rst_out", out_, 8'h00);
        reset_n = 1'b1;
        tick();

        // basic pack
        in_ = 4'h3; in_val = 1'b1;
        tick();
        chk("basic_half1", {7'd0, half}, 8'd1);
        chk("basic_val0", {7'd0, out_val}, 8'd0);
        in_ = 4'hA;
        tick();
        chk("basic_out", out_, 8'hA3);
        chk("basic_val1", {7'd0, out_val}, 8'd1);
        chk("basic_half0", {7'd0, half}, 8'd0);
        in_val = 1'b0;
        tick();
        chk("basic_drain", {7'd0, out_val}, 8'd0);

        // streaming 1..6
        in_val = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            in_ = 4'(i);
            #1;
            chk($sformatf("strm_rdy%0d", i), {7'd0, in_rdy}, 8'd1);
            tick();
            if (i % 2 == 0) begin
                chk($sformatf("strm_val%0d", i), {7'd0, out_val}, 8'd1);
                chk($sformatf("strm_out%0d", i), out_,
                    {4'(i), 4'(i - 1)});
            end else begin
                chk($sformatf("strm_val%0d", i), {7'd0, out_val}, 8'd0);
                chk($sformatf("strm_half%0d", i), {7'd0, half}, 8'd1);
            end
        end
        in_val = 1'b0;
        tick();
        chk("strm_drain", {7'd0, out_val}, 8'd0);

        // back-pressure
        out_rdy = 1'b0;
        in_val  = 1'b1;
        in_ = 4'h1; tick();
        in_ = 4'h2; tick();
        chk("bp_pend_val", {7'd0, out_val}, 8'd1);
        chk("bp_pend_out", out_, 8'h21);
        in_ = 4'h3; #1;
        chk("bp_lo_rdy", {7'd0, in_rdy}, 8'd1);
        tick();
        chk("bp_lo_half", {7'd0, half}, 8'd1);
        chk("bp_hold1", out_, 8'h21);
        in_ = 4'h4; #1;
        chk("bp_hi_stall", {7'd0, in_rdy}, 8'd0);
        tick();
        chk("bp_hold2", out_, 8'h21);
        chk("bp_still_half", {7'd0, half}, 8'd1);
        out_rdy = 1'b1; #1;
        chk("bp_rdy_rise", {7'd0, in_rdy}, 8'd1);
        tick();
        chk("bp_next_out", out_, 8'h43);
        chk("bp_next_val", {7'd0, out_val}, 8'd1);
        in_val = 1'b0;
        tick();
        chk("bp_drain", {7'd0, out_val}, 8'd0);

        // simultaneous drain and load
        out_rdy = 1'b0;
        in_val  = 1'b1;
        in_ = 4'h5; tick();
        in_ = 4'h6; tick();
        in_ = 4'h7; tick();
        chk("sim_pre_out", out_, 8'h65);
        chk("sim_pre_half", {7'd0, half}, 8'd1);
        out_rdy = 1'b1;
        in_ = 4'h9;
        tick();
        chk("sim_val", {7'd0, out_val}, 8'd1);
        chk("sim_out", out_, 8'h97);
        in_val = 1'b0;
        tick();
        chk("sim_drain", {7'd0, out_val}, 8'd0);

        // held low nibble persists with no partner
        in_val = 1'b1; in_ = 4'hE; tick();
        in_val = 1'b0; tick(); tick();
        chk("persist_half", {7'd0, half}, 8'd1);
        chk("persist_val", {7'd0, out_val}, 8'd0);
        in_val = 1'b1; in_ = 4'hF; tick();
        chk("persist_out", out_, 8'hFE);
        in_val = 1'b0; tick();

`ifdef PACK_FLUSH_EN
        in_val = 1'b1; in_ = 4'hC; tick();
        in_val = 1'b0; flush = 1'b1;
        tick();
        chk("fl_out", out_, 8'h0C);
        chk("fl_val", {7'd0, out_val}, 8'd1);
        chk("fl_half", {7'd0, half}, 8'd0);
        tick();
        chk("fl_empty_val1", {7'd0, out_val}, 8'd0);
        tick();
        chk("fl_empty_val2", {7'd0, out_val}, 8'd0);
        flush = 1'b0;
`endif

        // reset mid-stream with pending byte and held nibble
        out_rdy = 1'b0;
        in_val  = 1'b1;
        in_ = 4'hC; tick();
        in_ = 4'hD; tick();
        in_ = 4'hB; tick();
        chk("mid_pre_half", {7'd0, half}, 8'd1);
        chk("mid_pre_out", out_, 8'hDC);
        reset_n = 1'b0;
        tick();
        chk("mid_rst_val", {7'd0, out_val}, 8'd0);
        chk("mid_rst_half", {7'd0, half}, 8'd0);
        chk("mid_rst_rdy", {7'd0, in_rdy}, 8'd1);
        chk("mid_rst_out", out_, 8'h00);
        in_val  = 1'b0;
        out_rdy = 1'b1;
        reset_n = 1'b1;
        tick();
        in_val = 1'b1; in_ = 4'h8; tick();
        in_ = 4'h1; tick();
        chk("post_rst_out", out_, 8'h18);
        in_val = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
